weight_read_scheduler: RTL and testbench

Arbitrates a single 2-D weight memory (ROWS lines × COLS words of WIDTH bits, one full line per read) between two requesters, typically two neuron/layer engines. Each requester asks for a burst of consecutive rows starting at a given row; the scheduler grants round-robin, sequences the row addresses into the memory with wrap-around, and returns each line tagged with the requester id. It sits between the weight memory and the compute engines and is the only block allowed to drive the memory read port.

---
 rtl/weight_read_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_weight_read_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_read_scheduler.sv
// weight_read_scheduler
// Shares one weight memory read port between two requesters. A requester
// asks for a burst of consecutive rows; the winner is chosen round-robin,
// its row addresses are issued with wrap-around, and each returned line is
// tagged with the owner id. Every output except data_out is registered.

module weight_read_scheduler #(
  parameter int WIDTH = 4,
  parameter int COLS  = 3,
  parameter int ROWS  = 3,
  parameter int AW    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req,
  input  logic [2*AW-1:0]         req_row,
  input  logic [2*(AW+1)-1:0]     req_len,
  output logic [1:0]              ack,
  output logic                    busy,
  output logic                    mem_rd_en,
  output logic [AW-1:0]           mem_row_addr,
  input  logic [COLS*WIDTH-1:0]   mem_rd_data,
  output logic [COLS*WIDTH-1:0]   data_out,
  output logic                    data_valid,
  output logic                    data_id,
  output logic                    data_last
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int            LAST_ROW_I = ROWS - 1;
  localparam logic [AW:0]   ROWS_LEN   = ROWS[AW:0];
  localparam logic [AW-1:0] LAST_ROW   = LAST_ROW_I[AW-1:0];
  localparam logic [AW-1:0] ONE_ROW    = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   ONE_LEN    = {{AW{1'b0}}, 1'b1};

  state_t          state, state_next;
  logic [AW-1:0]   cur_row, cur_row_next;
  logic [AW:0]     remain, remain_next;
  logic            rr_favor, rr_next;

  logic [1:0]      ack_next;
  logic            busy_next;
  logic            rd_en_next;
  logic [AW-1:0]   addr_next;
  logic            valid_next;
  logic            id_next;
  logic            last_next;

  logic            grant_id;
  logic [AW-1:0]   sel_row;
  logic [AW:0]     sel_len;
  logic [AW-1:0]   start_row;
  logic [AW:0]     burst_len;

  // Next row in memory order, wrapping from the last line back to row 0.
  function automatic logic [AW-1:0] next_row(input logic [AW-1:0] row);
    return (row == LAST_ROW) ? '0 : row + ONE_ROW;
  endfunction

  // The memory line is handed straight back to the engines.
  assign data_out = mem_rd_data;

  // Pick the winner and sanitise its start row and length.
  always_comb begin
    grant_id  = 1'b0;
    sel_row   = req_row[AW-1:0];
    sel_len   = req_len[AW:0];
    start_row = '0;
    burst_len = ROWS_LEN;

    if (req == 2'b11) begin
      grant_id = rr_favor;
    end else begin
      grant_id = req[1];
    end

    if (grant_id) begin
      sel_row = req_row[2*AW-1:AW];
      sel_len = req_len[2*(AW+1)-1:AW+1];
    end

    if ({1'b0, sel_row} >= ROWS_LEN) begin
      start_row = '0;
    end else begin
      start_row = sel_row;
    end

    if ((sel_len == '0) || (sel_len > ROWS_LEN)) begin
      burst_len = ROWS_LEN;
    end else begin
      burst_len = sel_len;
    end
  end

  // Next-state logic and next values for every registered output.
  always_comb begin
    state_next   = state;
    cur_row_next = cur_row;
    remain_next  = remain;
    rr_next      = rr_favor;
    ack_next     = 2'b00;
    busy_next    = busy;
    rd_en_next   = 1'b0;
    addr_next    = '0;
    valid_next   = mem_rd_en;
    id_next      = data_id;
    last_next    = 1'b0;

    case (state)
      IDLE: begin
        busy_next = 1'b0;
        if (req != 2'b00) begin
          state_next   = ISSUE;
          ack_next     = grant_id ? 2'b10 : 2'b01;
          busy_next    = 1'b1;
          rd_en_next   = 1'b1;
          addr_next    = start_row;
          cur_row_next = next_row(start_row);
          remain_next  = burst_len - ONE_LEN;
          id_next      = grant_id;
        end
      end

      ISSUE: begin
        busy_next = 1'b1;
        if (remain != '0) begin
          rd_en_next   = 1'b1;
          addr_next    = cur_row;
          cur_row_next = next_row(cur_row);
          remain_next  = remain - ONE_LEN;
        end else begin
          state_next = DRAIN;
          last_next  = 1'b1;
        end
      end

      DRAIN: begin
        state_next = IDLE;
        busy_next  = 1'b0;
        rr_next    = ~data_id;
      end

      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  // State, burst bookkeeping and output registers; reset aborts any burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cur_row      <= '0;
      remain       <= '0;
      rr_favor     <= 1'b0;
      ack          <= 2'b00;
      busy         <= 1'b0;
      mem_rd_en    <= 1'b0;
      mem_row_addr <= '0;
      data_valid   <= 1'b0;
      data_id      <= 1'b0;
      data_last    <= 1'b0;
    end else begin
      state        <= state_next;
      cur_row      <= cur_row_next;
      remain       <= remain_next;
      rr_favor     <= rr_next;
      ack          <= ack_next;
      busy         <= busy_next;
      mem_rd_en    <= rd_en_next;
      mem_row_addr <= addr_next;
      data_valid   <= valid_next;
      data_id      <= id_next;
      data_last    <= last_next;
    end
  end

endmodule

// File: tb/tb_weight_read_scheduler.sv
// tb_weight_read_scheduler
// Drives bursts into weight_read_scheduler with a simple memory model and
// predicts the row sequence, returned lines and arbitration order from the
// burst rules directly.

module tb_weight_read_scheduler;

  localparam int WIDTH = 4;
  localparam int COLS  = 3;
  localparam int ROWS  = 3;
  localparam int AW    = 2;
  localparam int DW    = COLS * WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    req = 2'b00;
  logic [3:0]    req_row = '0;
  logic [5:0]    req_len = '0;
  logic [1:0]    ack;
  logic          busy;
  logic          mem_rd_en;
  logic [AW-1:0] mem_row_addr;
  logic [DW-1:0] mem_rd_data = '0;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          data_id;
  logic          data_last;

  logic [DW-1:0] mem [0:3];

  int checks = 0;
  int passes = 0;
  int favor  = 0;

  weight_read_scheduler #(
    .WIDTH(WIDTH), .COLS(COLS), .ROWS(ROWS), .AW(AW)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_row(req_row), .req_len(req_len),
    .ack(ack), .busy(busy), .mem_rd_en(mem_rd_en), .mem_row_addr(mem_row_addr),
    .mem_rd_data(mem_rd_data), .data_out(data_out), .data_valid(data_valid),
    .data_id(data_id), .data_last(data_last)
  );

  always #5 clk = ~clk;

  // Weight memory: line appears one cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_row_addr];
  end

  task automatic set_req(input logic [1:0] r, input int row0, input int len0,
                         input int row1, input int len1);
    req_row = {row1[1:0], row0[1:0]};
    req_len = {len1[2:0], len0[2:0]};
    req     = r;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst   = 1'b1;
    favor = 0;
  endtask

  // Waits for ack, then checks the whole burst cycle by cycle.
  task automatic run_burst(input string name, input int exp_id, input int row,
                           input int len, input bit drop_req,
                           input bit probe_withdraw, output int waited);
    int r, n;
    int rows[$];
    logic [1:0] exp_ack;
    r = (row >= ROWS) ? 0 : row;
    n = (len == 0 || len > ROWS) ? ROWS : len;
    for (int k = 0; k < n; k++) rows.push_back((r + k) % ROWS);
    exp_ack = (exp_id == 1) ? 2'b10 : 2'b01;

    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (ack === 2'b00 && waited < 20);
    checks++;
    if (ack === 2'b00) begin
      $display("[TB] FAIL %s ack_timeout: ack=%b required %b", name, ack, exp_ack);
      return;
    end
    passes++;
    if (drop_req) req = 2'b00;

    for (int k = 0; k <= n; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (ack !== ((k == 0) ? exp_ack : 2'b00))
        $display("[TB] FAIL %s ack[%0d]: got %b required %b", name, k, ack, (k == 0) ? exp_ack : 2'b00);
      else passes++;
      checks++;
      if (busy !== 1'b1) $display("[TB] FAIL %s busy[%0d]: got %b required 1", name, k, busy);
      else passes++;
      checks++;
      if (mem_rd_en !== (k < n)) $display("[TB] FAIL %s rd_en[%0d]: got %b required %b", name, k, mem_rd_en, (k < n));
      else passes++;
      if (k < n) begin
        checks++;
        if (mem_row_addr !== rows[k][AW-1:0])
          $display("[TB] FAIL %s addr[%0d]: got %0d required %0d", name, k, mem_row_addr, rows[k]);
        else passes++;
      end
      checks++;
      if (data_valid !== (k >= 1)) $display("[TB] FAIL %s valid[%0d]: got %b required %b", name, k, data_valid, (k >= 1));
      else passes++;
      if (k >= 1) begin
        checks++;
        if (data_out !== mem[rows[k-1]])
          $display("[TB] FAIL %s data[%0d]: got %h required %h", name, k, data_out, mem[rows[k-1]]);
        else passes++;
        checks++;
        if (data_id !== exp_id[0]) $display("[TB] FAIL %s id[%0d]: got %b required %0d", name, k, data_id, exp_id);
        else passes++;
      end
      checks++;
      if (data_last !== (k == n)) $display("[TB] FAIL %s last[%0d]: got %b required %b", name, k, data_last, (k == n));
      else passes++;
      if (probe_withdraw && k == 1) set_req(2'b01, 0, 1, 0, 1);
      if (probe_withdraw && k == n) req = 2'b00;
    end

    @(negedge clk);
    checks++;
    if ({busy, mem_rd_en, data_valid, data_last, ack} !== 6'b0)
      $display("[TB] FAIL %s idle_after: got busy=%b en=%b valid=%b last=%b ack=%b required all 0",
               name, busy, mem_rd_en, data_valid, data_last, ack);
    else passes++;
    favor = 1 - exp_id;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({ack, busy, mem_rd_en, mem_row_addr, data_valid, data_id, data_last} !== 9'b0)
      $display("[TB] FAIL reset_outputs: got %b required 0",
               {ack, busy, mem_rd_en, mem_row_addr, data_valid, data_id, data_last});
    else passes++;
    checks++;
    if (data_out !== mem_rd_data) $display("[TB] FAIL reset_passthrough: got %h required %h", data_out, mem_rd_data);
    else passes++;
    rst   = 1'b1;
    favor = 0;
  endtask

  task automatic test_single();
    int w;
    set_req(2'b01, 1, 2, 0, 0);
    run_burst("single", 0, 1, 2, 1'b1, 1'b0, w);
    checks++;
    if (w !== 1) $display("[TB] FAIL single_latency: ack after %0d cycles required 1", w);
    else passes++;
  endtask

  task automatic test_wrap();
    int w;
    set_req(2'b10, 0, 0, 2, 3);
    run_burst("wrap", 1, 2, 3, 1'b1, 1'b0, w);
  endtask

  task automatic test_edges();
    int w;
    set_req(2'b01, 3, 0, 0, 0);
    run_burst("edge_row3_len0", 0, 3, 0, 1'b1, 1'b0, w);
    set_req(2'b10, 0, 0, 1, 7);
    run_burst("edge_len7", 1, 1, 7, 1'b1, 1'b0, w);
  endtask

  task automatic test_contention();
    int w;
    set_req(2'b11, 0, 1, 1, 2);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ack !== 2'b00) $display("[TB] FAIL contention_in_reset: ack=%b required 00", ack);
    else passes++;
    rst   = 1'b1;
    favor = 0;
    run_burst("contention_a", 0, 0, 1, 1'b0, 1'b0, w);
    run_burst("contention_b", 1, 1, 2, 1'b0, 1'b0, w);
    checks++;
    if (w !== 1) $display("[TB] FAIL contention_gap_b: ack after %0d cycles required 1", w);
    else passes++;
    run_burst("contention_c", 0, 0, 1, 1'b1, 1'b0, w);
    checks++;
    if (w !== 1) $display("[TB] FAIL contention_gap_c: ack after %0d cycles required 1", w);
    else passes++;
  endtask

  task automatic test_reset_mid_burst();
    int w;
    set_req(2'b01, 0, 1, 0, 0);
    run_burst("pre_abort", 0, 0, 1, 1'b1, 1'b0, w);
    set_req(2'b10, 0, 0, 0, 3);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (ack === 2'b00 && w < 20);
    checks++;
    if (ack !== 2'b10) $display("[TB] FAIL abort_ack: ack=%b required 10", ack);
    else passes++;
    req = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({ack, busy, mem_rd_en, mem_row_addr, data_valid, data_id, data_last} !== 9'b0)
      $display("[TB] FAIL abort_outputs: got %b required 0",
               {ack, busy, mem_rd_en, mem_row_addr, data_valid, data_id, data_last});
    else passes++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({data_last, data_valid, busy} !== 3'b0)
        $display("[TB] FAIL abort_hold[%0d]: last=%b valid=%b busy=%b required 0", i, data_last, data_valid, busy);
      else passes++;
    end
    rst   = 1'b1;
    favor = 0;
    set_req(2'b11, 2, 2, 0, 1);
    run_burst("after_abort", 0, 2, 2, 1'b1, 1'b0, w);
  endtask

  task automatic test_withdraw();
    int w;
    set_req(2'b10, 0, 0, 0, 3);
    run_burst("withdraw_host", 1, 0, 3, 1'b1, 1'b1, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (ack !== 2'b00 || mem_rd_en !== 1'b0)
        $display("[TB] FAIL withdraw[%0d]: ack=%b rd_en=%b required 00/0", i, ack, mem_rd_en);
      else passes++;
    end
  endtask

  task automatic test_random();
    int w, mask, r0, r1, l0, l1, id;
    for (int it = 0; it < 30; it++) begin
      mask = $urandom_range(1, 3);
      r0 = $urandom_range(0, 3);
      r1 = $urandom_range(0, 3);
      l0 = $urandom_range(0, 7);
      l1 = $urandom_range(0, 7);
      id = (mask == 3) ? favor : ((mask == 2) ? 1 : 0);
      set_req(mask[1:0], r0, l0, r1, l1);
      run_burst("random", id, (id == 1) ? r1 : r0, (id == 1) ? l1 : l0, 1'b1, 1'b0, w);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = DW'($urandom);
    test_reset();
    test_single();
    test_wrap();
    test_edges();
    test_contention();
    test_reset_mid_burst();
    test_withdraw();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
